// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - signal bundle between the game sequencer and the snake/food/display blocks
interface snake_game_ctrl_if;
   logic       start_btn;
   logic       hit_wall;
   logic       hit_body;
   logic       food_eaten;
   logic [1:0] game_status;
   logic       move_tick;
   logic       snake_rst_n;
   logic       die_flash;
   logic       inc_len;
   logic [7:0] score;
   logic [2:0] lives;

   modport master (
      input  start_btn, hit_wall, hit_body, food_eaten,
      output game_status, move_tick, snake_rst_n, die_flash, inc_len, score, lives
   );

   modport slave (
      output start_btn, hit_wall, hit_body, food_eaten,
      input  game_status, move_tick, snake_rst_n, die_flash, inc_len, score, lives
   );
endinterface

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - game status FSM, move timebase, death blink, growth handshake, score and lives
module snake_game_ctrl #(
   parameter int MOVE_PERIOD    = 12500000,
   parameter int START_TICKS    = 8,
   parameter int FLASH_PERIOD   = 6250000,
   parameter int FLASH_COUNT    = 6,
   parameter int START_LIVES    = 3,
   parameter int INC_LEN_CYCLES = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   snake_game_ctrl_if.master gif
);
   localparam int MW = $clog2(MOVE_PERIOD);
   localparam int FW = $clog2(FLASH_PERIOD + 1);
   localparam int TW = $clog2(START_TICKS + 1);
   localparam int CW = $clog2(FLASH_COUNT + 1);
   localparam int IW = $clog2(INC_LEN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, PLAY = 2'b10, DIE = 2'b11} state_e;

   state_e        state_q, state_d;
   logic [MW-1:0] move_cnt_q, move_cnt_d, move_next;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic [CW-1:0] toggle_cnt_q, toggle_cnt_d;
   logic [IW-1:0] inc_cnt_q, inc_cnt_d;
   logic          start_prev_q, food_prev_q;
   logic          move_tick_q, move_tick_d;
   logic          snake_rst_n_q, snake_rst_n_d;
   logic          die_flash_q, die_flash_d;
   logic          inc_len_q, inc_len_d;
   logic [7:0]    score_q, score_d;
   logic [2:0]    lives_q, lives_d;
   logic          start_rise, food_rise, hit;

   assign start_rise = gif.start_btn & ~start_prev_q;
   assign food_rise  = gif.food_eaten & ~food_prev_q;
   assign hit        = gif.hit_wall | gif.hit_body;
   assign move_next  = (move_cnt_q == MW'(MOVE_PERIOD - 1)) ? '0 : move_cnt_q + MW'(1);

   always_comb begin
      state_d       = state_q;
      move_cnt_d    = move_cnt_q;
      tick_cnt_d    = tick_cnt_q;
      flash_cnt_d   = flash_cnt_q;
      toggle_cnt_d  = toggle_cnt_q;
      inc_cnt_d     = inc_cnt_q;
      move_tick_d   = 1'b0;
      snake_rst_n_d = snake_rst_n_q;
      die_flash_d   = 1'b1;
      inc_len_d     = 1'b0;
      score_d       = score_q;
      lives_d       = lives_q;
      case (state_q)
         IDLE: begin
            move_cnt_d    = '0;
            tick_cnt_d    = '0;
            inc_cnt_d     = '0;
            snake_rst_n_d = 1'b0;
            if (start_rise) begin
               state_d = START;
               lives_d = 3'(START_LIVES);
               score_d = '0;
            end
         end
         START: begin
            snake_rst_n_d = 1'b1;
            move_cnt_d    = move_next;
            move_tick_d   = (move_next == MW'(MOVE_PERIOD - 1));
            // the tick being shown now is counted; the last one hands over to PLAY
            if (move_tick_q) begin
               if (tick_cnt_q == TW'(START_TICKS - 1)) begin
                  state_d    = PLAY;
                  tick_cnt_d = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         PLAY: begin
            snake_rst_n_d = 1'b1;
            move_cnt_d    = move_next;
            move_tick_d   = (move_next == MW'(MOVE_PERIOD - 1));
            if (inc_cnt_q != '0) begin
               inc_cnt_d = inc_cnt_q - IW'(1);
               inc_len_d = (inc_cnt_q > IW'(1));
            end
            if (hit) begin
               state_d      = DIE;
               move_cnt_d   = '0;
               move_tick_d  = 1'b0;
               inc_cnt_d    = '0;
               inc_len_d    = 1'b0;
               flash_cnt_d  = '0;
               toggle_cnt_d = '0;
            end else if (food_rise && inc_cnt_q == '0) begin
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
               inc_cnt_d = IW'(INC_LEN_CYCLES);
               inc_len_d = 1'b1;
            end
         end
         DIE: begin
            move_cnt_d  = '0;
            die_flash_d = die_flash_q;
            if (toggle_cnt_q == CW'(FLASH_COUNT)) begin
               die_flash_d   = 1'b1;
               snake_rst_n_d = 1'b0;
               flash_cnt_d   = '0;
               toggle_cnt_d  = '0;
               lives_d       = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
               state_d       = (lives_q <= 3'd1) ? IDLE : START;
            end else if (flash_cnt_q == FW'(FLASH_PERIOD - 1)) begin
               flash_cnt_d  = '0;
               die_flash_d  = ~die_flash_q;
               toggle_cnt_d = toggle_cnt_q + CW'(1);
            end else begin
               flash_cnt_d = flash_cnt_q + FW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         move_cnt_q    <= '0;
         tick_cnt_q    <= '0;
         flash_cnt_q   <= '0;
         toggle_cnt_q  <= '0;
         inc_cnt_q     <= '0;
         start_prev_q  <= 1'b0;
         food_prev_q   <= 1'b0;
         move_tick_q   <= 1'b0;
         snake_rst_n_q <= 1'b0;
         die_flash_q   <= 1'b1;
         inc_len_q     <= 1'b0;
         score_q       <= '0;
         lives_q       <= 3'(START_LIVES);
      end else begin
         state_q       <= state_d;
         move_cnt_q    <= move_cnt_d;
         tick_cnt_q    <= tick_cnt_d;
         flash_cnt_q   <= flash_cnt_d;
         toggle_cnt_q  <= toggle_cnt_d;
         inc_cnt_q     <= inc_cnt_d;
         start_prev_q  <= gif.start_btn;
         food_prev_q   <= gif.food_eaten;
         move_tick_q   <= move_tick_d;
         snake_rst_n_q <= snake_rst_n_d;
         die_flash_q   <= die_flash_d;
         inc_len_q     <= inc_len_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
      end
   end

   assign gif.game_status = state_q;
   assign gif.move_tick   = move_tick_q;
   assign gif.snake_rst_n = snake_rst_n_q;
   assign gif.die_flash   = die_flash_q;
   assign gif.inc_len     = inc_len_q;
   assign gif.score       = score_q;
   assign gif.lives       = lives_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - vector table, directed corner sequences and random play against a timeline model
module tb_snake_game_ctrl;
   localparam int P  = 4;
   localparam int ST = 2;
   localparam int FP = 2;
   localparam int FC = 2;
   localparam int SL = 2;
   localparam int IL = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   snake_game_ctrl_if gif();

   snake_game_ctrl #(
      .MOVE_PERIOD(P), .START_TICKS(ST), .FLASH_PERIOD(FP),
      .FLASH_COUNT(FC), .START_LIVES(SL), .INC_LEN_CYCLES(IL)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .gif     (gif)
   );

   always #5 clk = ~clk;

   // Model state: status plus ages measured in cycles since the relevant entry
   int   m_st = 0, m_age = 0, m_run = 0, m_score = 0, m_lives = SL;
   int   m_grow_end = -1, cyc = 0;
   logic m_start_prev = 1'b0, m_food_prev = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      int  ns, nl;
      logic srise, frise;
      if (rst) begin
         m_st = 0; m_age = 0; m_run = 0; m_score = 0; m_lives = SL;
         m_grow_end = -1; m_start_prev = 1'b0; m_food_prev = 1'b0;
      end else begin
         srise = gif.start_btn && !m_start_prev;
         frise = gif.food_eaten && !m_food_prev;
         ns = m_st;
         case (m_st)
            0: if (srise) begin ns = 1; m_lives = SL; m_score = 0; end
            1: if ((m_run % P == P - 1) && ((m_run + 1) / P == ST)) ns = 2;
            2: begin
               if (gif.hit_wall || gif.hit_body) begin
                  ns = 3; m_grow_end = -1;
               end else if (frise && !(cyc <= m_grow_end)) begin
                  m_score = (m_score < 255) ? m_score + 1 : 255;
                  m_grow_end = cyc + IL;
               end
            end
            default: if (m_age == FC * FP) begin
               nl = (m_lives > 0) ? m_lives - 1 : 0;
               m_lives = nl;
               ns = (nl == 0) ? 0 : 1;
            end
         endcase
         m_run = (ns == 1 && m_st != 1) ? 0 : m_run + 1;
         m_age = (ns != m_st) ? 0 : m_age + 1;
         m_st = ns;
         m_start_prev = gif.start_btn;
         m_food_prev = gif.food_eaten;
      end
      cyc++;
   endtask

   task automatic model_check();
      chk("model_status", int'(gif.game_status), m_st);
      chk("model_move_tick", int'(gif.move_tick), int'((m_st == 1 || m_st == 2) && (m_run % P == P - 1)));
      chk("model_snake_rst_n", int'(gif.snake_rst_n), int'(!(m_st == 0 || (m_st == 1 && m_age == 0))));
      chk("model_die_flash", int'(gif.die_flash), (m_st == 3) ? int'((m_age / FP) % 2 == 0) : 1);
      chk("model_inc_len", int'(gif.inc_len), int'(m_st == 2 && cyc <= m_grow_end));
      chk("model_score", int'(gif.score), m_score);
      chk("model_lives", int'(gif.lives), m_lives);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      model_check();
   endtask

   task automatic wait_status(input int target, input int limit, input string name);
      for (int i = 0; i < limit; i++) begin
         if (int'(gif.game_status) == target) break;
         step();
      end
      chk(name, int'(gif.game_status), target);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_status"}, int'(gif.game_status), 0);
      chk({tag, "_move_tick"}, int'(gif.move_tick), 0);
      chk({tag, "_snake_rst_n"}, int'(gif.snake_rst_n), 0);
      chk({tag, "_die_flash"}, int'(gif.die_flash), 1);
      chk({tag, "_inc_len"}, int'(gif.inc_len), 0);
      chk({tag, "_score"}, int'(gif.score), 0);
      chk({tag, "_lives"}, int'(gif.lives), SL);
   endtask

   typedef struct packed {
      logic       rst, start, hw, hb, food;
      logic [1:0] st;
      logic       tick, rstn, flash, inc;
      logic [7:0] score;
      logic [2:0] lives;
   } vec_t;

   vec_t vecs[24];

   initial begin
      // reset, START with two ticks, PLAY, food with a dropped second edge, hit+food, death blink, restart
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 3'd2};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 3'd2};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 3'd2};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd2};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd2};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd2};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd2};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd2};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd2};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd2};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 3'd1};
      vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd1};

      gif.start_btn = 1'b0; gif.hit_wall = 1'b0; gif.hit_body = 1'b0; gif.food_eaten = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) begin
         rst = vecs[i].rst; gif.start_btn = vecs[i].start; gif.hit_wall = vecs[i].hw;
         gif.hit_body = vecs[i].hb; gif.food_eaten = vecs[i].food;
         step();
         chk($sformatf("vec%0d_status", i), int'(gif.game_status), int'(vecs[i].st));
         chk($sformatf("vec%0d_move_tick", i), int'(gif.move_tick), int'(vecs[i].tick));
         chk($sformatf("vec%0d_snake_rst_n", i), int'(gif.snake_rst_n), int'(vecs[i].rstn));
         chk($sformatf("vec%0d_die_flash", i), int'(gif.die_flash), int'(vecs[i].flash));
         chk($sformatf("vec%0d_inc_len", i), int'(gif.inc_len), int'(vecs[i].inc));
         chk($sformatf("vec%0d_score", i), int'(gif.score), int'(vecs[i].score));
         chk($sformatf("vec%0d_lives", i), int'(gif.lives), int'(vecs[i].lives));
      end
      gif.hit_wall = 1'b0; gif.food_eaten = 1'b0; gif.start_btn = 1'b0;

      // second death ends the game; a held start button does not restart it
      wait_status(2, 20, "g2_reach_play");
      gif.hit_body = 1'b1;
      step();
      gif.hit_body = 1'b0;
      gif.start_btn = 1'b1;
      wait_status(0, 20, "g2_reach_idle");
      chk("g2_lives_zero", int'(gif.lives), 0);
      chk("g2_score_kept", int'(gif.score), 1);
      for (int i = 0; i < 5; i++) step();
      chk("held_start_stays_idle", int'(gif.game_status), 0);
      gif.start_btn = 1'b0;
      step();
      gif.start_btn = 1'b1;
      step();
      chk("restart_status", int'(gif.game_status), 1);
      chk("restart_lives", int'(gif.lives), SL);
      chk("restart_score", int'(gif.score), 0);
      gif.start_btn = 1'b0;

      // score saturation
      wait_status(2, 20, "sat_reach_play");
      for (int n = 0; n < 255; n++) begin
         gif.food_eaten = 1'b1;
         step();
         gif.food_eaten = 1'b0;
         for (int k = 0; k < 4; k++) step();
      end
      chk("score_at_255", int'(gif.score), 255);
      gif.food_eaten = 1'b1;
      step();
      chk("sat_inc_len_pulses", int'(gif.inc_len), 1);
      chk("sat_score_holds", int'(gif.score), 255);
      gif.food_eaten = 1'b0;
      step();

      // reset in the middle of DIE
      gif.hit_wall = 1'b1;
      step();
      gif.hit_wall = 1'b0;
      chk("mid_die_status", int'(gif.game_status), 3);
      step();
      step();
      rst = 1'b1;
      step();
      chk_reset_values("rst_die");
      rst = 1'b0;

      // reset while inc_len is high
      gif.start_btn = 1'b1;
      step();
      gif.start_btn = 1'b0;
      wait_status(2, 20, "rst_inc_reach_play");
      gif.food_eaten = 1'b1;
      step();
      chk("rst_inc_pre", int'(gif.inc_len), 1);
      rst = 1'b1;
      gif.food_eaten = 1'b0;
      step();
      chk_reset_values("rst_inc");
      rst = 1'b0;
      step();
      chk("rst_inc_no_stray", int'(gif.inc_len), 0);

      // random play against the model
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 399) == 0);
         gif.start_btn  = ($urandom_range(0, 7) == 0);
         gif.hit_wall   = ($urandom_range(0, 59) == 0);
         gif.hit_body   = ($urandom_range(0, 79) == 0);
         gif.food_eaten = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Top-level game sequencer for the snake datapath.
- Owns the game_status FSM (IDLE/START/PLAY/DIE) and the move-tick timebase.
- Generates the snake datapath's active-low reset, die_flash blink and inc_len growth handshake; keeps score and lives.
- Sits between the button debouncers, the snake datapath and the food generator; feeds game_status to the VGA/score display.

Parameters:
- MOVE_PERIOD, 12500000: clk cycles between move_tick pulses (>=2).
- START_TICKS, 8: move ticks spent in START before PLAY (>=1).
- FLASH_PERIOD, 6250000: clk cycles per die_flash half-period (>=1).
- FLASH_COUNT, 6: die_flash toggles in DIE before leaving (even, >=2).
- START_LIVES, 3: lives loaded on new game (1..7).
- INC_LEN_CYCLES, 4: cycles inc_len is held high per food (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain, no other clocks
- start_btn  in  1  debounced start button, level; rising edge detected internally
- hit_wall  in  1  from snake datapath, level
- hit_body  in  1  from snake datapath, level
- food_eaten  in  1  from food generator, level; rising edge counts
- game_status  out  2  IDLE=2'b00, START=2'b01, PLAY=2'b10, DIE=2'b11
- move_tick  out  1  one-cycle pulse, PLAY and START only
- snake_rst_n  out  1  active-low reset to snake datapath
- die_flash  out  1  1 = draw snake, 0 = blank
- inc_len  out  1  growth request, held INC_LEN_CYCLES cycles
- score  out  8  foods eaten this game, saturating at 255
- lives  out  3  remaining lives

Behaviour:
- Reset (sync, priority over everything):
  - game_status=IDLE, snake_rst_n=0, die_flash=1, move_tick=0, inc_len=0, score=0, lives=START_LIVES.
  - Move, flash, tick and inc counters = 0; edge-detect registers = 0.
- All outputs are registered; every FSM transition takes effect the cycle after its condition is sampled.
- Move counter:
  - Runs only in START and PLAY; cleared in IDLE, in DIE, and on entry to START.
  - move_tick=1 for exactly one cycle when the counter reaches MOVE_PERIOD-1; counter wraps to 0 the same cycle.
  - First tick occurs MOVE_PERIOD cycles after state entry.
- IDLE:
  - snake_rst_n=0, die_flash=1.
  - score and lives hold their last values, so the final score stays displayed.
  - start_btn rising edge -> START: load lives=START_LIVES, clear score.
  - start_btn edges in any other state are ignored.
- START:
  - snake_rst_n=0 for exactly the first cycle in START, then 1.
  - die_flash=1.
  - After START_TICKS move ticks -> PLAY. The state change occurs the cycle after the last tick; the move counter is not cleared.
- PLAY:
  - snake_rst_n=1, die_flash=1.
  - (hit_wall | hit_body) sampled high -> DIE. This has priority over food on the same cycle: no score, no inc_len.
  - food_eaten rising edge with no hit:
    - score+1 (hold at 255).
    - inc_len=1 starting next cycle for INC_LEN_CYCLES cycles, then 0.
    - Food edges arriving while inc_len is high are dropped.
- DIE:
  - move_tick=0.
  - die_flash toggles every FLASH_PERIOD cycles, starting at 1; first toggle to 0 after FLASH_PERIOD cycles.
  - inc_len is forced 0 on entry; any pending growth is discarded.
  - After FLASH_COUNT toggles (die_flash back to 1), lives decrements.
    - New lives==0 -> IDLE.
    - Otherwise -> START, which re-pulses snake_rst_n; score is kept.
  - hit inputs are ignored in DIE.
- lives never underflows; score never wraps.

Test Plan:
Benches use MOVE_PERIOD=4, START_TICKS=2, FLASH_PERIOD=2, FLASH_COUNT=2, START_LIVES=2, INC_LEN_CYCLES=3.
1. Reset, then start_btn high at cycle 5 -> status 00->01 at cycle 6; snake_rst_n low only at cycle 6; ticks at cycles 9 and 13; status=10 at cycle 14; lives=2, score=0.
2. In PLAY, food_eaten 0->1 held 10 cycles -> score=1; inc_len high exactly 3 cycles starting the cycle after the edge; a second edge during those 3 cycles -> ignored, score stays 1.
3. In PLAY, hit_wall and a food edge on the same cycle -> status=11 next cycle; score unchanged; inc_len=0; die_flash sequence 1,1,0,0,1; then lives=1 and status=01 with a 1-cycle snake_rst_n low pulse.
4. Second death -> lives=0, status=00; score holds its last value; start_btn held high without a new edge -> stays IDLE; new rising edge -> lives=2, score=0.
5. Force score=255 (255 food edges) then one more edge -> score stays 255, inc_len still pulses.
6. Assert reset mid-DIE and mid-inc_len -> next cycle all outputs equal their reset values; move_tick=0; no stray inc_len.
